freq_meter_mc: RTL and testbench
================================

Name: freq_meter_mc

Overview:
Multi-channel, single-clock-domain successor to the single-channel frequency counter. It measures NCH external test signals by sampling them with refclk_i. Each input is synchronised, rising edges are counted over a runtime-programmable gate window of refclk_i cycles, and every channel's count is latched at window end with a one-cycle valid strobe. Windows run back-to-back with no dead cycles. This block is the measurement front end for clock-monitor and rate-check logic. Inputs must toggle slower than refclk_i/2.

Parameters:
NCH, 4, number of measured channels
CNT_W, 32, per-channel edge-count width
GATE_W, 32, gate-length register width
SYNC_STAGES, 2, synchroniser flops per channel (minimum 2)

Ports:
refclk_i  input  1  sole clock; all logic on its rising edge
rst_i  input  1  asynchronous, active-high reset
en_i  input  1  measurement enable
gate_len_i  input  GATE_W  window length in refclk_i cycles; 0 is treated as 1
tst_i  input  NCH  asynchronous test signals
freq_cnt_o  output  NCH*CNT_W  latched counts; channel c occupies bits [c*CNT_W +: CNT_W]
ovf_o  output  NCH  per-channel saturation flag for the latched window
valid_o  output  1  one-cycle strobe; freq_cnt_o and ovf_o updated this cycle
busy_o  output  1  high while in MEAS

Behaviour:
- Reset values (async assert):
  - all outputs 0
  - state IDLE
  - synchroniser, edge-history, channel-counter and gate-counter regs 0
- Synchroniser and edge detect:
  - per channel, SYNC_STAGES flops, then a history flop
  - edge[c] = sync_out & ~hist
  - history tracks in every state, so entering MEAS never creates a false edge
  - input-to-edge latency is SYNC_STAGES+1 cycles
- State machine has two states.
  - IDLE:
    - counters held at 0
    - on en_i=1, load N = max(gate_len_i,1), clear gate_cnt, go to MEAS
  - MEAS:
    - every cycle, cnt[c] increments on edge[c]
    - cnt saturates at 2^CNT_W-1 and sets a sticky ovf_int[c] on an attempted increment past the max
    - gate_cnt increments each cycle
  - Window end (MEAS cycle with gate_cnt==N-1):
    - freq_cnt_o[c] <= cnt[c] plus this cycle's edge, saturating
    - ovf_o[c] <= ovf_int[c] | saturation on this cycle
    - valid_o <= 1 for exactly the next cycle
    - cnt and ovf_int cleared, gate_cnt <= 0
    - N reloaded from the current gate_len_i
    - an edge on the first cycle of the new window counts in the new window
    - net effect: a window of N cycles spans exactly N edge samples
  - en_i=0 while in MEAS:
    - next cycle IDLE; partial counts discarded; no valid_o
    - freq_cnt_o and ovf_o hold their last values
    - en_i=0 on the window-end cycle itself: the latch and valid still occur, then IDLE
- gate_len_i changes are ignored mid-window and take effect at the next reload.
- busy_o = (state==MEAS).
- freq_cnt_o and ovf_o change only on valid_o cycles or on reset.
- Reset mid-window: everything returns to reset values immediately; the first valid_o after release comes no earlier than N+1 cycles after en_i is seen high.
- Frequency = count * f_ref / N. Any conversion is outside this block.

Test Plan:
1. Window timing: NCH=4, tst_i=0, gate_len_i=5, en_i high from cycle 0 after reset → valid_o pulses every 5 cycles, first valid_o at the 6th edge after en_i seen; freq_cnt_o=0, ovf_o=0.
2. Count accuracy: ch0 rising every 10 refclk cycles, ch1 every 4, ch2 constant 1, ch3 every 7; gate_len_i=1000 → steady-state counts 100, 250, 0, 142 or 143; ch2 stays 0 with no false edge on entry.
3. Saturation: CNT_W=8, ch0 toggling every cycle (edge every 2 cycles), gate_len_i=1000 → freq_cnt_o ch0=255, ovf_o[0]=1; the next window at gate_len_i=100 gives 50, ovf_o[0]=0.
4. Gate update: gate_len_i switched 1000→200 mid-window → current window still closes at 1000 cycles; subsequent valid_o spacing is 200; gate_len_i=0 gives valid_o every cycle.
5. Enable abort: en_i dropped at cycle 500 of 1000 → no valid_o, busy_o low the next cycle, outputs keep the previous window's values; re-enable gives a full fresh window.
6. Async reset mid-window: rst_i pulsed between clock edges at cycle 300 → outputs 0 immediately, no valid_o before a full N cycles after re-enable.

Source files
------------

// File: rtl/freq_meter_mc.sv
// Multi-channel frequency meter: counts synchronised rising edges of NCH
// test inputs over a programmable refclk_i gate window, back-to-back.
// Ports: refclk_i clock, rst_i async active-high reset, en_i enable,
//   gate_len_i window length (0 acts as 1), tst_i async test inputs,
//   freq_cnt_o latched counts (ch c at [c*CNT_W +: CNT_W]), ovf_o per-channel
//   saturation, valid_o one-cycle update strobe, busy_o high while measuring.
module freq_meter_mc #(
   parameter int NCH         = 4,
   parameter int CNT_W       = 32,
   parameter int GATE_W      = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 refclk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic [GATE_W-1:0]    gate_len_i,
   input  logic [NCH-1:0]       tst_i,
   output logic [NCH*CNT_W-1:0] freq_cnt_o,
   output logic [NCH-1:0]       ovf_o,
   output logic                 valid_o,
   output logic                 busy_o
);

   typedef enum logic {IDLE, MEAS} state_t;

   state_t                               state_q;
   logic [SYNC_STAGES-1:0][NCH-1:0]      sync_q;
   logic [NCH-1:0]                       hist_q;
   logic [NCH-1:0]                       edge_w;
   logic [NCH-1:0][CNT_W-1:0]            cnt_q;
   logic [NCH-1:0][CNT_W-1:0]            cnt_nx;
   logic [NCH-1:0]                       ovf_int_q;
   logic [NCH-1:0]                       sat_hit;
   logic [GATE_W-1:0]                    gate_cnt_q;
   logic [GATE_W-1:0]                    n_q;
   logic [GATE_W-1:0]                    gate_len_eff;
   logic                                 win_end;

   // History keeps tracking in IDLE so entering MEAS never sees a stale edge.
   always_ff @(posedge refclk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
         hist_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], tst_i};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_w = sync_q[SYNC_STAGES-1] & ~hist_q;

   // Saturating next count including this cycle's edge.
   always_comb begin
      cnt_nx  = cnt_q;
      sat_hit = '0;
      for (int c = 0; c < NCH; c++) begin
         if (edge_w[c]) begin
            if (&cnt_q[c]) sat_hit[c] = 1'b1;
            else           cnt_nx[c]  = cnt_q[c] + CNT_W'(1);
         end
      end
   end

   assign gate_len_eff = (gate_len_i == '0) ? GATE_W'(1) : gate_len_i;
   assign win_end      = (gate_cnt_q == n_q - GATE_W'(1));

   always_ff @(posedge refclk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ovf_int_q  <= '0;
         gate_cnt_q <= '0;
         n_q        <= '0;
         freq_cnt_o <= '0;
         ovf_o      <= '0;
         valid_o    <= 1'b0;
         busy_o     <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         unique case (state_q)
            IDLE: begin
               cnt_q     <= '0;
               ovf_int_q <= '0;
               if (en_i) begin
                  n_q        <= gate_len_eff;
                  gate_cnt_q <= '0;
                  state_q    <= MEAS;
                  busy_o     <= 1'b1;
               end
            end
            MEAS: begin
               if (win_end) begin
                  // Latch includes the final cycle's edge; next window
                  // starts clean on the following cycle.
                  freq_cnt_o <= cnt_nx;
                  ovf_o      <= ovf_int_q | sat_hit;
                  valid_o    <= 1'b1;
                  cnt_q      <= '0;
                  ovf_int_q  <= '0;
                  gate_cnt_q <= '0;
                  n_q        <= gate_len_eff;
                  if (!en_i) begin
                     state_q <= IDLE;
                     busy_o  <= 1'b0;
                  end
               end else if (!en_i) begin
                  cnt_q      <= '0;
                  ovf_int_q  <= '0;
                  gate_cnt_q <= '0;
                  state_q    <= IDLE;
                  busy_o     <= 1'b0;
               end else begin
                  cnt_q      <= cnt_nx;
                  ovf_int_q  <= ovf_int_q | sat_hit;
                  gate_cnt_q <= gate_cnt_q + GATE_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_freq_meter_mc.sv
// Self-checking bench for freq_meter_mc: directed scenarios plus random
// stimulus compared every cycle against a window-level reference model.
module tb_freq_meter_mc;

   localparam int NCH = 4;
   localparam int CW  = 8;
   localparam int GW  = 32;
   localparam int SS  = 2;
   localparam int LIM = 3000;

   logic              refclk_i = 1'b0;
   logic              rst_i;
   logic              en_i;
   logic [GW-1:0]     gate_len_i;
   logic [NCH-1:0]    tst_i = '0;
   logic [NCH*CW-1:0] freq_cnt_o;
   logic [NCH-1:0]    ovf_o;
   logic              valid_o;
   logic              busy_o;

   freq_meter_mc #(
      .NCH(NCH), .CNT_W(CW), .GATE_W(GW), .SYNC_STAGES(SS)
   ) dut (
      .refclk_i(refclk_i), .rst_i(rst_i), .en_i(en_i),
      .gate_len_i(gate_len_i), .tst_i(tst_i),
      .freq_cnt_o(freq_cnt_o), .ovf_o(ovf_o),
      .valid_o(valid_o), .busy_o(busy_o)
   );

   always #5 refclk_i = ~refclk_i;

   int n_chk  = 0;
   int n_fail = 0;
   bit mon_on = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Test-signal generator: period p (rise every p cycles) or held level.
   int  per [NCH];
   bit  hold[NCH];
   int  ph  [NCH];
   initial for (int c = 0; c < NCH; c++) begin
      per[c] = 0; hold[c] = 0; ph[c] = 0;
   end

   always @(posedge refclk_i) begin
      #1;
      for (int c = 0; c < NCH; c++) begin
         ph[c]++;
         if (per[c] == 0) tst_i[c] = hold[c];
         else             tst_i[c] = (ph[c] % per[c]) < (per[c] / 2);
      end
   end

   // Reference model: windows of N refclk samples; an input rise seen at
   // sample s is counted at the sample SS later. Counts are unbounded
   // integers clipped to 2^CW-1 when a window closes.
   logic [NCH-1:0]    hq[$];
   bit                act;
   int                wlen, pos;
   int                wc[NCH];
   logic [NCH*CW-1:0] m_freq;
   logic [NCH-1:0]    m_ovf;
   bit                m_valid, m_busy;

   task automatic m_reset();
      hq.delete();
      for (int i = 0; i < SS + 2; i++) hq.push_back('0);
      act = 0; wlen = 1; pos = 0;
      for (int c = 0; c < NCH; c++) wc[c] = 0;
      m_freq = '0; m_ovf = '0; m_valid = 0; m_busy = 0;
   endtask

   function automatic int eff_len(input logic [GW-1:0] g);
      return (g == 0) ? 1 : int'(g);
   endfunction

   always @(posedge refclk_i or posedge rst_i) begin
      if (rst_i) begin
         m_reset();
      end else begin
         logic [NCH-1:0] e;
         hq.push_front(tst_i);
         void'(hq.pop_back());
         e = hq[SS] & ~hq[SS+1];
         m_valid = 0;
         if (act) begin
            for (int c = 0; c < NCH; c++) wc[c] += int'(e[c]);
            pos++;
            if (pos == wlen) begin
               for (int c = 0; c < NCH; c++) begin
                  m_freq[c*CW +: CW] = (wc[c] > 255) ? 8'hff : 8'(wc[c]);
                  m_ovf[c] = (wc[c] > 255);
                  wc[c] = 0;
               end
               m_valid = 1;
               if (en_i) begin
                  wlen = eff_len(gate_len_i);
                  pos  = 0;
               end else act = 0;
            end else if (!en_i) begin
               act = 0;
               for (int c = 0; c < NCH; c++) wc[c] = 0;
            end
         end else if (en_i) begin
            act  = 1;
            wlen = eff_len(gate_len_i);
            pos  = 0;
            for (int c = 0; c < NCH; c++) wc[c] = 0;
         end
         m_busy = act;
      end
   end

   always @(negedge refclk_i) begin
      if (mon_on) begin
         chk("valid", 64'(valid_o), 64'(m_valid));
         chk("busy",  64'(busy_o),  64'(m_busy));
         chk("freq",  64'(freq_cnt_o), 64'(m_freq));
         chk("ovf",   64'(ovf_o),   64'(m_ovf));
      end
   end

   // Waits for the next valid_o (from a negedge); n = negedges waited.
   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(negedge refclk_i);
         n++;
      end while (!valid_o && n < LIM);
      if (!valid_o) chk("valid_timeout", 64'd0, 64'd1);
   endtask

   function automatic logic [CW-1:0] ch(input int c);
      return freq_cnt_o[c*CW +: CW];
   endfunction

   int n;

   initial begin
      rst_i      = 1'b1;
      en_i       = 1'b0;
      gate_len_i = 5;
      m_reset();
      repeat (3) @(negedge refclk_i);
      mon_on = 1;
      rst_i  = 1'b0;
      @(negedge refclk_i);
      chk("rst_freq",  64'(freq_cnt_o), 64'd0);
      chk("rst_ovf",   64'(ovf_o), 64'd0);
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_busy",  64'(busy_o), 64'd0);

      // Window timing, idle inputs.
      en_i = 1'b1;
      wait_valid(n); chk("t1_first", 64'(n), 64'd6);
      wait_valid(n); chk("t1_sp0", 64'(n), 64'd5);
      wait_valid(n); chk("t1_sp1", 64'(n), 64'd5);
      chk("t1_freq", 64'(freq_cnt_o), 64'd0);
      chk("t1_ovf",  64'(ovf_o), 64'd0);

      // Count accuracy.
      per[0] = 10; per[1] = 4; per[2] = 0; hold[2] = 1; per[3] = 7;
      gate_len_i = 1000;
      wait_valid(n); wait_valid(n); wait_valid(n);
      chk("t2_sp",  64'(n), 64'd1000);
      chk("t2_ch0", 64'(ch(0)), 64'd100);
      chk("t2_ch1", 64'(ch(1)), 64'd250);
      chk("t2_ch2", 64'(ch(2)), 64'd0);
      chk("t2_ch3", 64'(ch(3) == 142 || ch(3) == 143), 64'd1);

      // Saturation then recovery on a short window.
      per[0] = 2;
      gate_len_i = 100;
      wait_valid(n);
      chk("t3_sat",  64'(ch(0)), 64'd255);
      chk("t3_ovf",  64'(ovf_o[0]), 64'd1);
      wait_valid(n);
      chk("t3_cnt",  64'(ch(0)), 64'd50);
      chk("t3_novf", 64'(ovf_o[0]), 64'd0);

      // Gate updates take effect at reload only.
      gate_len_i = 1000;
      wait_valid(n); chk("t4_sp100", 64'(n), 64'd100);
      repeat (10) @(negedge refclk_i);
      gate_len_i = 200;
      wait_valid(n); chk("t4_sp1000", 64'(n + 10), 64'd1000);
      wait_valid(n); chk("t4_sp200a", 64'(n), 64'd200);
      gate_len_i = 0;
      wait_valid(n); chk("t4_sp200b", 64'(n), 64'd200);
      wait_valid(n); chk("t4_sp1a", 64'(n), 64'd1);
      wait_valid(n); chk("t4_sp1b", 64'(n), 64'd1);

      // Enable abort mid-window.
      gate_len_i = 1000;
      wait_valid(n);
      repeat (500) @(negedge refclk_i);
      en_i = 1'b0;
      @(negedge refclk_i);
      chk("t5_busy",  64'(busy_o), 64'd0);
      chk("t5_valid", 64'(valid_o), 64'd0);
      repeat (20) @(negedge refclk_i);
      en_i = 1'b1;
      wait_valid(n); chk("t5_fresh", 64'(n), 64'd1001);

      // Async reset mid-window.
      for (int c = 0; c < NCH; c++) begin per[c] = 0; hold[c] = 0; end
      repeat (300) @(negedge refclk_i);
      #2 rst_i = 1'b1;
      #1;
      chk("t6_freq",  64'(freq_cnt_o), 64'd0);
      chk("t6_ovf",   64'(ovf_o), 64'd0);
      chk("t6_valid", 64'(valid_o), 64'd0);
      chk("t6_busy",  64'(busy_o), 64'd0);
      @(negedge refclk_i);
      #2 rst_i = 1'b0;
      wait_valid(n); chk("t6_first", 64'(n), 64'd1001);

      // Random stimulus against the model.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge refclk_i);
         if (cyc % 300 == 0) begin
            for (int c = 0; c < NCH; c++) begin
               if ($urandom_range(0, 3) == 0) begin
                  per[c]  = 0;
                  hold[c] = bit'($urandom_range(0, 1));
               end else per[c] = int'($urandom_range(2, 23));
            end
         end
         if ($urandom_range(0, 49) == 0) en_i = ~en_i;
         if ($urandom_range(0, 19) == 0)
            gate_len_i = ($urandom_range(0, 7) == 0) ?
                         GW'($urandom_range(300, 700)) :
                         GW'($urandom_range(0, 40));
      end

      @(negedge refclk_i);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
